// File: rtl/parity_pkg.sv
// Shared definitions for the parity serial link: frame states, frame geometry
// and the parity function also used by the receive-side checker.
package parity_pkg;

  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_BITS      = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Returns the parity bit that makes the total count of ones even or odd.
  function automatic logic calc_parity(input logic [FRAME_DATA_BITS-1:0] data,
                                       input logic odd_sel);
    return odd_sel ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/parity_serial_tx_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick_o
// on the last cycle of each bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tick_o = en_i && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parity_serial_tx.sv
// Byte-wide serial transmitter: start, 8 data bits LSB-first, parity, stop.
// Define PARITY_ERR_INJECT_EN to add err_inject / inject_cnt for parity fault injection.
module parity_serial_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and in_valid is ignored at all other times.
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       odd_sel,
`ifdef PARITY_ERR_INJECT_EN
  input  logic       err_inject,
  output logic [7:0] inject_cnt,
`endif
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  state_e                     state_q, state_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                 idx_q, idx_d;
  logic                       par_q, par_d;
  logic                       tx_q, tx_d;
  logic                       accept, tick;

  assign accept     = in_valid && (state_q == IDLE);
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && tick;
  assign tx         = tx_q;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (busy),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = in_data;
`ifdef PARITY_ERR_INJECT_EN
          par_d   = calc_parity(in_data, odd_sel) ^ err_inject;
`else
          par_d   = calc_parity(in_data, odd_sel);
`endif
        end
      end
      START:  if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'(FRAME_DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next-state view so the line changes on the
  // same edge as the state, with no path from the inputs to the pin.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

`ifdef PARITY_ERR_INJECT_EN
  logic [7:0] inj_cnt_q, inj_cnt_d;

  assign inject_cnt = inj_cnt_q;

  always_comb begin
    inj_cnt_d = inj_cnt_q;
    if (accept && err_inject && (inj_cnt_q != 8'hFF)) begin
      inj_cnt_d = inj_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_cnt_q <= '0;
    end else begin
      inj_cnt_q <= inj_cnt_d;
    end
  end
`endif

endmodule
